// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
//   state_t      : responder FSM states
//   WAIT_CNT_W   : width of the wait-state counter
//   WORD_BYTES   : byte lanes per 32-bit word
//   merge_lanes  : overlay enabled byte lanes of a new word onto an old word
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int WAIT_CNT_W = 4;
    localparam int WORD_BYTES = 4;

    function automatic logic [31:0] merge_lanes(input logic [31:0]           old_word,
                                                input logic [31:0]           new_word,
                                                input logic [WORD_BYTES-1:0] be);
        logic [31:0] w;
        w = old_word;
        for (int i = 0; i < WORD_BYTES; i++)
            if (be[i]) w[8*i +: 8] = new_word[8*i +: 8];
        return w;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// WORDS x 32-bit storage, one byte-wide memory per lane so each lane has its
// own synchronous write enable; combinational read. No reset on contents.
//   clk   : clock
//   we    : per-lane write enables
//   addr  : word index (shared by read and write)
//   wdata : lane-placed write word
//   rdata : current word at addr
module dmem_array
    import dmem_pkg::*;
#(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic [WORD_BYTES-1:0] we,
    input  logic [AW-1:0]         addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    for (genvar g = 0; g < WORD_BYTES; g++) begin : g_lane
        logic [7:0] mem [WORDS];

        always_ff @(posedge clk) begin
            if (we[g]) mem[addr] <= wdata[8*g +: 8];
        end

        assign rdata[8*g +: 8] = mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the LSU. Accepts one aligned word request in IDLE,
// waits WAIT_STATES cycles, commits any byte-masked write on the edge into
// RESP and presents the resulting word with a one-cycle MemReady pulse.
//   clk, reset  : clock, async active-high reset
//   MemEn       : request present
//   IEUAdr      : byte address (bits [1:0] ignored)
//   StoreData   : lane-placed store word
//   WriteByteEn : lane enables, zero means read
//   ReadData    : response word, valid with MemReady
//   MemReady    : one-cycle completion pulse
//   MemStall    : pipeline hold (MemEn & ~MemReady)
//   AccessFault : out-of-range flag, valid with MemReady
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          WORDS       = 1024,
    parameter logic [31:0] BASE_ADR    = 32'h0000_2000,
    parameter int          WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemEn,
    input  logic [31:0]           IEUAdr,
    input  logic [31:0]           StoreData,
    input  logic [WORD_BYTES-1:0] WriteByteEn,
    output logic [31:0]           ReadData,
    output logic                  MemReady,
    output logic                  MemStall,
    output logic                  AccessFault
);

    localparam int AW = $clog2(WORDS);
    // 33-bit bounds so BASE_ADR near the top of the address space cannot wrap
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADR} + (33'(WORDS) << 2);
    localparam logic [WAIT_CNT_W-1:0] WS_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    state_t                state, state_nxt;
    logic [WAIT_CNT_W-1:0] cnt;
    logic                  accept;
    logic                  enter_resp;

    logic [AW-1:0]         idx_in, idx_q, idx_eff;
    logic [31:0]           sdata_q, sdata_eff;
    logic [WORD_BYTES-1:0] be_q, be_eff;
    logic                  inr_in, inr_q, inr_eff;

    logic [WORD_BYTES-1:0] arr_we;
    logic [31:0]           arr_rd;

    assign inr_in = ({1'b0, IEUAdr} >= {1'b0, BASE_ADR}) && ({1'b0, IEUAdr} < LIMIT);
    assign idx_in = AW'((IEUAdr - BASE_ADR) >> 2);

    // In IDLE the live request drives the datapath; this matters only with
    // zero wait states, where accept and the commit edge coincide. Elsewhere
    // the latched request is used so input changes are ignored.
    assign idx_eff   = (state == IDLE) ? idx_in      : idx_q;
    assign sdata_eff = (state == IDLE) ? StoreData   : sdata_q;
    assign be_eff    = (state == IDLE) ? WriteByteEn : be_q;
    assign inr_eff   = (state == IDLE) ? inr_in      : inr_q;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (MemEn) begin
                accept    = 1'b1;
                state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
            end
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_resp = (state_nxt == RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            idx_q    <= '0;
            sdata_q  <= '0;
            be_q     <= '0;
            inr_q    <= 1'b0;
            ReadData <= '0;
        end else begin
            if (accept) begin
                cnt     <= WS_LOAD;
                idx_q   <= idx_in;
                sdata_q <= StoreData;
                be_q    <= WriteByteEn;
                inr_q   <= inr_in;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            // Array read is pre-commit on this edge, so overlay the write
            // lanes to present the post-commit word.
            if (enter_resp)
                ReadData <= inr_eff ? merge_lanes(arr_rd, sdata_eff, be_eff) : '0;
        end
    end

    assign arr_we = be_eff & {WORD_BYTES{enter_resp & inr_eff}};

    dmem_array #(.WORDS(WORDS), .AW(AW)) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (idx_eff),
        .wdata (sdata_eff),
        .rdata (arr_rd)
    );

    assign MemReady    = (state == RESP);
    assign AccessFault = (state == RESP) & ~inr_q;
    assign MemStall    = MemEn & ~MemReady & ~reset;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int          WORDS = 1024;
    localparam logic [31:0] BASE  = 32'h0000_2000;
    localparam int          WS    = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // main instance (WAIT_STATES=2)
    logic        MemEn = 1'b0;
    logic [31:0] IEUAdr = '0, StoreData = '0;
    logic [3:0]  WriteByteEn = '0;
    logic [31:0] ReadData;
    logic        MemReady, MemStall, AccessFault;

    // zero-wait-state instance
    logic        en0 = 1'b0;
    logic [31:0] adr0 = '0, sd0 = '0;
    logic [3:0]  be0 = '0;
    logic [31:0] rd0;
    logic        rdy0, stall0, fault0;

    dmem_responder #(.WORDS(WORDS), .BASE_ADR(BASE), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .MemEn(MemEn), .IEUAdr(IEUAdr),
        .StoreData(StoreData), .WriteByteEn(WriteByteEn), .ReadData(ReadData),
        .MemReady(MemReady), .MemStall(MemStall), .AccessFault(AccessFault));

    dmem_responder #(.WORDS(WORDS), .BASE_ADR(BASE), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .MemEn(en0), .IEUAdr(adr0),
        .StoreData(sd0), .WriteByteEn(be0), .ReadData(rd0),
        .MemReady(rdy0), .MemStall(stall0), .AccessFault(fault0));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rd;
        logic        fault;
        int          at;
    } exp_t;
    exp_t q[$];

    // reference contents of the first 16 words
    logic [31:0] model [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        logic [63:0] a64, lo, hi;
        a64 = {32'b0, a};
        lo  = {32'b0, BASE};
        hi  = lo + 64'(4 * WORDS);
        return (a64 >= lo) && (a64 < hi);
    endfunction

    // One request on the main instance; blocks until its MemReady (bounded).
    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        exp_t e;
        int   k;
        bit   seen;
        @(posedge clk); #1;
        MemEn = 1'b1; IEUAdr = a; StoreData = d; WriteByteEn = be;
        if (in_rng(a)) begin
            k = int'((a - BASE) >> 2);
            for (int b = 0; b < 4; b++)
                if (be[b]) model[k][8*b +: 8] = d[8*b +: 8];
            e.rd = model[k];
            e.fault = 1'b0;
        end else begin
            e.rd = '0;
            e.fault = 1'b1;
        end
        e.at = cyc + 1 + WS;
        q.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < WS + 6 && !seen; i++) begin
            @(negedge clk);
            if (MemReady) begin
                seen = 1'b1;
                check("stall_at_ready", {31'b0, MemStall}, 32'd0);
            end else begin
                check("stall_waiting", {31'b0, MemStall}, 32'd1);
            end
            // request is latched by now; wiggle inputs to prove they are ignored
            if (i >= 1) begin
                IEUAdr = $urandom; StoreData = $urandom; WriteByteEn = 4'($urandom);
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got no MemReady expected pulse at cycle %0d", e.at);
        end
        @(posedge clk); #1;
        MemEn = 1'b0; IEUAdr = $urandom; StoreData = $urandom; WriteByteEn = 4'($urandom);
    endtask

    // scoreboard monitor for the main instance
    always @(negedge clk) begin
        if (MemReady) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ready: got MemReady=1 expected no response (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("ready_cycle", 32'(cyc), 32'(e.at));
                check("read_data", ReadData, e.rd);
                check("access_fault", {31'b0, AccessFault}, {31'b0, e.fault});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish before 300000");
        $fatal(1);
    end

    logic [31:0] oor [5];

    initial begin
        logic [31:0] a, d;
        logic [3:0]  be;

        oor[0] = 32'h0000_1FFC; oor[1] = BASE + 32'(4 * WORDS); oor[2] = 32'hFFFF_FFFC;
        oor[3] = 32'h0;         oor[4] = BASE + 32'(4 * WORDS) + 32'd4;

        // reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_readdata", ReadData, 32'd0);
        check("rst_ready", {31'b0, MemReady}, 32'd0);
        check("rst_fault", {31'b0, AccessFault}, 32'd0);
        check("rst_stall", {31'b0, MemStall}, 32'd0);

        // give every modelled word a known value; word 2 (0x2008) is zero
        for (int k = 0; k < 16; k++)
            req(BASE + 32'(4 * k), (k == 2) ? 32'd0 : $urandom, 4'hF);

        // word write then read
        req(32'h2000, 32'hDEAD_BEEF, 4'hF);
        req(32'h2000, $urandom, 4'h0);

        // byte lane merge, then halfword
        req(32'h2004, 32'h1122_3344, 4'hF);
        req(32'h2004, 32'h00AA_0000, 4'b0100);
        req(32'h2004, $urandom, 4'h0);
        req(32'h2004, 32'hBEEF_0000, 4'b1100);
        req(32'h2004, $urandom, 4'h0);

        // out of range read and write; base word untouched
        req(32'h1FFC, $urandom, 4'h0);
        req(BASE + 32'(4 * WORDS), 32'hFFFF_FFFF, 4'hF);
        req(32'h2000, $urandom, 4'h0);

        // reset while the write to 0x2008 is waiting
        @(posedge clk); #1;
        MemEn = 1'b1; IEUAdr = 32'h2008; StoreData = 32'h5555_AAAA; WriteByteEn = 4'hF;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("midrst_readdata", ReadData, 32'd0);
        check("midrst_ready", {31'b0, MemReady}, 32'd0);
        check("midrst_fault", {31'b0, AccessFault}, 32'd0);
        check("midrst_stall", {31'b0, MemStall}, 32'd0);
        repeat (2) @(posedge clk);
        #1 MemEn = 1'b0; reset = 1'b0;
        repeat (4) @(posedge clk);
        req(32'h2008, $urandom, 4'h0);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            if ($urandom_range(0, 9) < 8)
                a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            else
                a = oor[$urandom_range(0, 4)];
            d  = $urandom;
            be = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            req(a, d, be);
        end
        check("queue_empty", 32'(q.size()), 32'd0);

        // zero wait states: MemEn held high -> accepts every other cycle
        @(posedge clk); #1;
        en0 = 1'b1; adr0 = 32'h2010; sd0 = 32'h1234_5678; be0 = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("ws0_ready", {31'b0, rdy0}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check("ws0_stall", {31'b0, stall0}, (i % 2 == 1) ? 32'd0 : 32'd1);
            if (i % 2 == 1) begin
                check("ws0_data", rd0, 32'h1234_5678);
                check("ws0_fault", {31'b0, fault0}, 32'd0);
            end
        end
        @(posedge clk); #1 en0 = 1'b0;
        @(posedge clk); #1;
        en0 = 1'b1; adr0 = 32'h1FFC; be0 = 4'h0;
        @(negedge clk);
        check("ws0_oor_wait", {31'b0, rdy0}, 32'd0);
        @(posedge clk); #1 en0 = 1'b0;
        @(negedge clk);
        check("ws0_oor_ready", {31'b0, rdy0}, 32'd1);
        check("ws0_oor_fault", {31'b0, fault0}, 32'd1);
        check("ws0_oor_data", rd0, 32'd0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory target for the sample processor's load/store unit. Accepts word-aligned requests (address, store word, byte enables, enable) and performs a byte-masked write or a full-word read after a configurable number of wait states. Returns the read word with a one-cycle ready pulse and drives a stall back to the pipeline. Byte and halfword placement and sign extension stay in the LSU; this block only ever sees aligned words plus lane enables.

Parameters:
WORDS, 1024, number of 32-bit words in the array (power of 2)
BASE_ADR, 32'h0000_2000, byte address of word 0
WAIT_STATES, 2, extra cycles between accept and response (0..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
MemEn  in  1  request present
IEUAdr  in  32  byte address; bits [1:0] ignored
StoreData  in  32  lane-placed store word
WriteByteEn  in  4  lane enables; nonzero = write, zero = read
ReadData  out  32  read word, valid while MemReady=1
MemReady  out  1  one-cycle completion pulse
MemStall  out  1  pipeline hold request
AccessFault  out  1  out-of-range flag, valid while MemReady=1

Behaviour:
- Reset, asynchronous: state IDLE, wait counter 0, ReadData=0, MemReady=0, AccessFault=0. Any pending request is dropped and its write is never committed. Array contents are not reset.
- FSM states are IDLE, WAIT and RESP.
- IDLE with MemEn=1:
  - Latch the word index (IEUAdr-BASE_ADR)>>2, StoreData, WriteByteEn and the in-range flag.
  - Next state is WAIT if WAIT_STATES>0, otherwise RESP.
- IDLE with MemEn=0: stay in IDLE.
- WAIT: the counter loads WAIT_STATES-1 on entry and decrements each cycle. Leave for RESP on the cycle the counter reads 0.
- Write commit: on the clock edge entering RESP, when in range, each lane i with WriteByteEn[i]=1 updates byte i. Lanes with enable 0 keep their value.
- RESP, held for exactly one cycle:
  - MemReady=1.
  - Read in range: ReadData = array word (post-commit contents).
  - Write in range: ReadData = post-commit word.
  - Out of range: ReadData=0, AccessFault=1, no array change.
  - Next state is always IDLE.
- Latency: request accepted at edge N gives MemReady high in cycle N+1+WAIT_STATES.
- Request spacing: a new request is accepted only in IDLE, so the minimum spacing is 2+WAIT_STATES cycles.
- Outside RESP: ReadData holds its last value, MemReady=0 and AccessFault=0.
- Range rule: in range iff BASE_ADR <= IEUAdr < BASE_ADR+4*WORDS, evaluated on all 32 address bits with no wrap-around.
- MemStall = MemEn & ~MemReady (combinational). It is 0 during reset.
- Input changes while in WAIT or RESP are ignored; the latched values are used.
- Ordering: a read issued after a write completes returns the written data, because the write has already committed.

Decomposition:
- Package dmem_pkg:
  - state typedef enum logic [1:0] {IDLE, WAIT, RESP}
  - WAIT_CNT_W = 4
  - WORD_BYTES = 4
- Sub-module dmem_array:
  - WORDS x 32 storage with a per-byte synchronous write enable and a combinational read port.
  - Keeps the storage inferable as block RAM separately from the FSM.

Test Plan:
- Reset check: hold reset high, then release -> ReadData=0, MemReady=0, AccessFault=0, MemStall=0 with MemEn=0. Assert reset mid-cycle (between edges) -> outputs go to 0 immediately.
- Word write then read, WAIT_STATES=2:
  - Write 0xDEADBEEF to 0x2000 with BE=1111, MemEn high from cycle 0 -> MemReady only in cycle 3 and MemStall high in cycles 0-2.
  - Then read 0x2000 -> ReadData=0xDEADBEEF in its MemReady cycle.
- Byte lane merge: write 0x11223344 to 0x2004, then write StoreData=0x00AA0000 with BE=0100 -> read 0x2004 returns 0x11AA3344. A halfword write of 0xBEEF0000 with BE=1100 -> read returns 0xBEEF3344.
- Out of range:
  - Read 0x1FFC -> MemReady=1, AccessFault=1, ReadData=0.
  - Write 0xFFFFFFFF to 0x2000+4*WORDS -> AccessFault=1.
  - Readback of 0x2000 is unchanged.
- Reset during WAIT: start a write of 0x5555AAAA to 0x2008 (old value 0), assert reset in cycle 1 -> no MemReady, and a later read of 0x2008 returns 0.
- WAIT_STATES=0 build: request in cycle 0 -> MemReady in cycle 1. Back-to-back requests held on MemEn -> accepted in cycles 0, 2 and 4 with ready pulses in cycles 1, 3 and 5.
